// File: rtl/pulse_train_gen_pkg.sv
// Shared definitions for output-timing blocks: phase encodings and default holdoff.
package pulse_train_gen_pkg;

  // Phase encodings, fixed so that other output-timing blocks can decode them.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StHigh  = 2'd1,
    StLow   = 2'd2,
    StGuard = 2'd3
  } pt_state_e;

  // Minimum low time in clk cycles that keeps far-end debouncers and edge
  // detectors able to resolve every edge.
  localparam int unsigned DefaultHoldoff = 16;

endpackage

// File: rtl/pulse_train_gen_cycle_timer.sv
// Loadable down-counter shared by the HIGH, LOW and GUARD phases.
// A load of value V starts a V-cycle duration; expired is high on its last cycle.
module pulse_train_gen_cycle_timer
  import pulse_train_gen_pkg::*;
#(
  parameter int unsigned TBITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TBITS-1:0] value,
  input  logic             en,
  output logic             expired
);

  logic [TBITS-1:0] cnt_q, cnt_d;

  // Next count: load value-1, otherwise count down and park at zero (never wraps).
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (value == '0) ? '0 : value - TBITS'(1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - TBITS'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Burst pulse generator: on start, emits N pulses of H active cycles followed by
// L idle cycles, with L never shorter than HOLDOFF. abort drops the pin to idle
// and holds busy for a HOLDOFF guard so the far end still sees a clean low.
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int unsigned TBITS      = 16,
  parameter int unsigned NBITS      = 8,
  parameter int unsigned HOLDOFF    = DefaultHoldoff,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [TBITS-1:0] high_cycles,
  input  logic [TBITS-1:0] low_cycles,
  input  logic [NBITS-1:0] pulses,
  output logic             pulse_out,
  output logic             busy,
  output logic             done
);

  // A zero holdoff would make the guard phase ill-defined; treat it as one cycle.
  localparam logic [TBITS-1:0] HoldoffT    = (HOLDOFF == 0) ? TBITS'(1) : TBITS'(HOLDOFF);
  localparam logic             ActiveLevel = ~IDLE_LEVEL;

  pt_state_e        state_q, state_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [TBITS-1:0] h_q, h_d;
  logic [TBITS-1:0] l_q, l_d;
  logic [NBITS-1:0] rem_q, rem_d;

  logic [TBITS-1:0] h_clamp, l_clamp;
  logic [NBITS-1:0] rem_dec;

  logic             tmr_load;
  logic [TBITS-1:0] tmr_value;
  logic             tmr_en;
  logic             tmr_expired;

  pulse_train_gen_cycle_timer #(
    .TBITS (TBITS)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .value   (tmr_value),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // Phase sequencing, timer control and next-state of all registered outputs.
  always_comb begin
    h_clamp = (high_cycles == '0) ? TBITS'(1) : high_cycles;
    l_clamp = (low_cycles < HoldoffT) ? HoldoffT : low_cycles;
    rem_dec = rem_q - NBITS'(1);

    state_d   = state_q;
    pulse_d   = pulse_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    h_d       = h_q;
    l_d       = l_q;
    rem_d     = rem_q;
    tmr_load  = 1'b0;
    tmr_value = h_q;
    tmr_en    = 1'b0;

    case (state_q)
      StIdle: begin
        pulse_d = IDLE_LEVEL;
        busy_d  = 1'b0;
        // abort in the same cycle suppresses the start.
        if (start && !abort && (pulses != '0)) begin
          h_d       = h_clamp;
          l_d       = l_clamp;
          rem_d     = pulses;
          tmr_load  = 1'b1;
          tmr_value = h_clamp;
          pulse_d   = ActiveLevel;
          busy_d    = 1'b1;
          state_d   = StHigh;
        end
      end

      StHigh: begin
        tmr_en = 1'b1;
        if (abort) begin
          pulse_d   = IDLE_LEVEL;
          tmr_load  = 1'b1;
          tmr_value = HoldoffT;
          state_d   = StGuard;
        end else if (tmr_expired) begin
          pulse_d   = IDLE_LEVEL;
          tmr_load  = 1'b1;
          tmr_value = l_q;
          state_d   = StLow;
        end
      end

      StLow: begin
        tmr_en = 1'b1;
        if (abort) begin
          pulse_d   = IDLE_LEVEL;
          tmr_load  = 1'b1;
          tmr_value = HoldoffT;
          state_d   = StGuard;
        end else if (tmr_expired) begin
          rem_d = rem_dec;
          if (rem_dec == '0) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            pulse_d   = ActiveLevel;
            tmr_load  = 1'b1;
            tmr_value = h_q;
            state_d   = StHigh;
          end
        end
      end

      StGuard: begin
        // Further aborts are ignored; the guard simply runs out.
        tmr_en = 1'b1;
        if (tmr_expired) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end

      default: begin
        pulse_d = IDLE_LEVEL;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset overrides start and abort.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pulse_q <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      h_q     <= '0;
      l_q     <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      h_q     <= h_d;
      l_q     <= l_d;
      rem_q   <= rem_d;
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;

  a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n) done_q |-> !busy_q);
  a_active_busy:   assert property (@(posedge clk) disable iff (!rst_n)
                                    (pulse_q == ActiveLevel) |-> busy_q);

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen. Two instances share stimulus, one per idle
// polarity, so every waveform check also covers the inverted pin.
module tb_pulse_train_gen;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [15:0] high_cycles, low_cycles;
  logic [7:0]  pulses;
  logic        pulse_lo, busy_lo, done_lo;
  logic        pulse_hi, busy_hi, done_hi;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int h;      // high_cycles applied
    int l;      // low_cycles applied
    int n;      // pulses applied
    int eh;     // expected high length after clamp
    int el;     // expected low length after clamp
    int total;  // expected busy cycles
  } burst_t;

  burst_t tbl[8];

  always #5 clk = ~clk;

  pulse_train_gen #(
    .TBITS      (16),
    .NBITS      (8),
    .HOLDOFF    (16),
    .IDLE_LEVEL (1'b0)
  ) dut_lo (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .high_cycles (high_cycles),
    .low_cycles  (low_cycles),
    .pulses      (pulses),
    .pulse_out   (pulse_lo),
    .busy        (busy_lo),
    .done        (done_lo)
  );

  pulse_train_gen #(
    .TBITS      (16),
    .NBITS      (8),
    .HOLDOFF    (16),
    .IDLE_LEVEL (1'b1)
  ) dut_hi (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .high_cycles (high_cycles),
    .low_cycles  (low_cycles),
    .pulses      (pulses),
    .pulse_out   (pulse_hi),
    .busy        (busy_hi),
    .done        (done_hi)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] required);
    n_cmp++;
    if (actual !== required) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, actual, required);
    end
  endtask

  // Start a burst and compare both instances against the ideal waveform from the
  // start edge until one cycle after done.
  task automatic run_burst(input burst_t b, input string tag);
    int   wave_lo, wave_hi, busy_len, done_cnt, rises;
    logic prev, ep, eb, ed;
    wave_lo = 0; wave_hi = 0; busy_len = 0; done_cnt = 0; rises = 0; prev = 1'b0;
    high_cycles = 16'(b.h);
    low_cycles  = 16'(b.l);
    pulses      = 8'(b.n);
    start       = 1'b1;
    tick();
    start       = 1'b0;
    // Mid-burst changes must not matter.
    high_cycles = 16'd7;
    low_cycles  = 16'd50;
    pulses      = 8'd9;
    for (int k = 0; k <= b.total + 1; k++) begin
      eb = (k < b.total);
      ep = eb && ((k % (b.eh + b.el)) < b.eh);
      ed = (k == b.total);
      if (pulse_lo !== ep || busy_lo !== eb || done_lo !== ed) wave_lo++;
      if (pulse_hi !== ~ep || busy_hi !== eb || done_hi !== ed) wave_hi++;
      if (busy_lo === 1'b1) busy_len++;
      if (done_lo === 1'b1) done_cnt++;
      if (pulse_lo === 1'b1 && !prev) rises++;
      prev = pulse_lo;
      if (k < b.total + 1) tick();
    end
    check({tag, " wave idle0 bad cycles"}, wave_lo, 0);
    check({tag, " wave idle1 bad cycles"}, wave_hi, 0);
    check({tag, " busy length"}, busy_len, b.total);
    check({tag, " done count"}, done_cnt, 1);
    check({tag, " pulse count"}, rises, b.n);
  endtask

  // Start a 3/20/2 burst, assert reset (with start) after k sampled cycles.
  task automatic reset_mid(input int at_k, input string tag);
    high_cycles = 16'd3; low_cycles = 16'd20; pulses = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (at_k) tick();
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    check({tag, " pulse idle0"}, pulse_lo, 0);
    check({tag, " pulse idle1"}, pulse_hi, 1);
    check({tag, " busy"}, busy_lo | busy_hi, 0);
    check({tag, " done"}, done_lo | done_hi, 0);
    tick();
    rst_n = 1'b1;
    start = 1'b0;
    tick();
  endtask

  initial begin
    int   act, blen, donec, rises, lvl24, lvl25, lvl25h;
    int   r[3];
    int   nr;
    logic prev;

    tbl[0] = '{3, 20, 2, 3, 20, 46};
    tbl[1] = '{1, 2, 3, 1, 16, 51};
    tbl[2] = '{0, 20, 1, 1, 20, 21};
    tbl[3] = '{5, 16, 1, 5, 16, 21};
    tbl[4] = '{2, 0, 4, 2, 16, 72};
    tbl[5] = '{0, 0, 2, 1, 16, 34};
    tbl[6] = '{1, 17, 1, 1, 17, 18};
    tbl[7] = '{1, 0, 255, 1, 16, 4335};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    high_cycles = '0; low_cycles = '0; pulses = '0;
    repeat (3) tick();
    check("reset pulse idle0", pulse_lo, 0);
    check("reset pulse idle1", pulse_hi, 1);
    check("reset busy", busy_lo | busy_hi, 0);
    check("reset done", done_lo | done_hi, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_burst(tbl[i], $sformatf("burst%0d", i));

    // start with pulses=0 is ignored.
    high_cycles = 16'd3; low_cycles = 16'd20; pulses = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    act = 0;
    repeat (4) begin
      if (busy_lo !== 1'b0 || done_lo !== 1'b0 || pulse_lo !== 1'b0 ||
          busy_hi !== 1'b0 || done_hi !== 1'b0 || pulse_hi !== 1'b1) act++;
      tick();
    end
    check("zero pulses active cycles", act, 0);

    // Repeated start during a 5-pulse burst (H=2, L=16): no queuing.
    high_cycles = 16'd2; low_cycles = 16'd4; pulses = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 8'd3;
    rises = 0; donec = 0; blen = 0; prev = 1'b0;
    for (int k = 0; k <= 92; k++) begin
      if (pulse_lo === 1'b1 && !prev) rises++;
      prev = pulse_lo;
      if (done_lo === 1'b1) donec++;
      if (busy_lo === 1'b1) blen++;
      start = ((k % 3) == 0) && (k < 88);
      tick();
    end
    start = 1'b0;
    check("restart pulse count", rises, 5);
    check("restart done count", donec, 1);
    check("restart busy length", blen, 90);

    // abort in the 2nd HIGH of N=4 (H=3, L=20), second abort lands in GUARD.
    high_cycles = 16'd3; low_cycles = 16'd20; pulses = 8'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    donec = 0; blen = 0; lvl24 = 0; lvl25 = 1; lvl25h = 0;
    for (int k = 0; k <= 45; k++) begin
      if (k == 24) lvl24 = int'(pulse_lo);
      if (k == 25) begin
        lvl25  = int'(pulse_lo);
        lvl25h = int'(pulse_hi);
      end
      if (done_lo === 1'b1 || done_hi === 1'b1) donec++;
      if (busy_lo === 1'b1) blen++;
      abort = (k == 24) || (k == 30);
      tick();
    end
    abort = 1'b0;
    check("abort pulse before", lvl24, 1);
    check("abort pulse idle0 after", lvl25, 0);
    check("abort pulse idle1 after", lvl25h, 1);
    check("abort busy length", blen, 41);
    check("abort done count", donec, 0);
    check("abort end busy", busy_lo | busy_hi, 0);

    // abort and start together in IDLE: start dropped, not queued.
    high_cycles = 16'd3; low_cycles = 16'd20; pulses = 8'd3;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort+start busy", busy_lo | busy_hi, 0);
    check("abort+start pulse", pulse_lo, 0);
    tick();
    check("abort+start busy later", busy_lo, 0);

    // start held high: each new burst starts on the edge after done, so rises
    // are (H+L)+1 = 19 cycles apart with busy high 18 of them.
    high_cycles = 16'd2; low_cycles = 16'd16; pulses = 8'd1;
    start = 1'b1;
    tick();
    nr = 0; blen = 0; donec = 0; prev = 1'b0;
    r[0] = 0; r[1] = 0; r[2] = 0;
    for (int k = 0; k <= 40; k++) begin
      if (pulse_lo === 1'b1 && !prev && nr < 3) begin
        r[nr] = k;
        nr++;
      end
      prev = pulse_lo;
      if (k < 19 && busy_lo === 1'b1) blen++;
      if (done_lo === 1'b1) donec++;
      tick();
    end
    start = 1'b0;
    check("held start rises", nr, 3);
    check("held start spacing 1", r[1] - r[0], 19);
    check("held start spacing 2", r[2] - r[1], 19);
    check("held start busy per burst", blen, 18);
    check("held start done count", donec, 2);
    act = 0;
    while (busy_lo !== 1'b0 && act < 40) begin
      tick();
      act++;
    end
    check("held start drain busy", busy_lo, 0);
    tick();

    reset_mid(10, "reset mid-low");
    run_burst(tbl[0], "after reset mid-low");
    reset_mid(24, "reset mid-high");
    run_burst(tbl[0], "after reset mid-high");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
